// File: rtl/dht11_slave_emu.sv
// DHT11 sensor-side emulator: detects the host start pulse, acknowledges, then
// sends a 40-bit humidity/temperature/checksum frame using DHT11 bit timing on a 1 us strobe.
module dht11_slave_emu #(
  parameter int unsigned START_MIN = 18000,
  parameter int unsigned RESP_WAIT = 30,
  parameter int unsigned ACK_LW    = 80,
  parameter int unsigned ACK_HG    = 80,
  parameter int unsigned BIT_LW    = 50,
  parameter int unsigned BIT0_HG   = 26,
  parameter int unsigned BIT1_HG   = 70,
  parameter int unsigned EOT_LW    = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       I_ST,
  input  logic       I_LINE,
  input  logic [7:0] I_HUM_INT,
  input  logic [7:0] I_HUM_DEC,
  input  logic [7:0] I_TMP_INT,
  input  logic [7:0] I_TMP_DEC,
  input  logic       I_ERR_INJ,
  output logic       O_DRIVE_LOW,
  output logic       O_BUSY,
  output logic       O_DONE
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_T = max2(START_MIN, max2(RESP_WAIT, max2(ACK_LW, max2(ACK_HG,
                                  max2(BIT_LW, max2(BIT0_HG, max2(BIT1_HG, EOT_LW)))))));
  localparam int unsigned CW = $clog2(MAX_T + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t START_MIN_C = cnt_t'(START_MIN);
  localparam cnt_t RESP_END    = cnt_t'(RESP_WAIT - 1);
  localparam cnt_t ACK_LW_END  = cnt_t'(ACK_LW - 1);
  localparam cnt_t ACK_HG_END  = cnt_t'(ACK_HG - 1);
  localparam cnt_t BIT_LW_END  = cnt_t'(BIT_LW - 1);
  localparam cnt_t BIT0_END    = cnt_t'(BIT0_HG - 1);
  localparam cnt_t BIT1_END    = cnt_t'(BIT1_HG - 1);
  localparam cnt_t EOT_END     = cnt_t'(EOT_LW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DET_LW, S_WAIT_REL, S_RSP_LW, S_RSP_HG, S_BIT_LW, S_BIT_HG, S_EOT
  } state_e;

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [39:0] frame_q, frame_d;
  logic        drive_q, drive_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        line_s1_q, line_s1_d;
  logic        line_s2_q, line_s2_d;
  logic [7:0]  csum_c;
  cnt_t        hg_end_c;

  always_comb begin
    line_s1_d = I_LINE;
    line_s2_d = line_s1_q;
    csum_c    = (I_HUM_INT + I_HUM_DEC + I_TMP_INT + I_TMP_DEC) ^ {7'd0, I_ERR_INJ};
    hg_end_c  = frame_q[idx_q] ? BIT1_END : BIT0_END;

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    drive_d = drive_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Each timed phase ends on the strobe where the counter reaches N-1.
    if (I_ST) begin
      unique case (state_q)
        S_IDLE: begin
          if (!line_s2_q) begin
            state_d = S_DET_LW;
            cnt_d   = cnt_t'(1);
          end
        end
        S_DET_LW: begin
          if (!line_s2_q) begin
            if (cnt_q < START_MIN_C) cnt_d = cnt_t'(cnt_q + 1'b1);
          end else if (cnt_q >= START_MIN_C) begin
            state_d = S_WAIT_REL;
            cnt_d   = '0;
            frame_d = {I_HUM_INT, I_HUM_DEC, I_TMP_INT, I_TMP_DEC, csum_c};
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_WAIT_REL: begin
          if (cnt_q == RESP_END) begin
            state_d = S_RSP_LW;
            cnt_d   = '0;
            drive_d = 1'b1;
          end else cnt_d = cnt_t'(cnt_q + 1'b1);
        end
        S_RSP_LW: begin
          if (cnt_q == ACK_LW_END) begin
            state_d = S_RSP_HG;
            cnt_d   = '0;
            drive_d = 1'b0;
          end else cnt_d = cnt_t'(cnt_q + 1'b1);
        end
        S_RSP_HG: begin
          if (cnt_q == ACK_HG_END) begin
            state_d = S_BIT_LW;
            cnt_d   = '0;
            idx_d   = 6'd39;
            drive_d = 1'b1;
          end else cnt_d = cnt_t'(cnt_q + 1'b1);
        end
        S_BIT_LW: begin
          if (cnt_q == BIT_LW_END) begin
            state_d = S_BIT_HG;
            cnt_d   = '0;
            drive_d = 1'b0;
          end else cnt_d = cnt_t'(cnt_q + 1'b1);
        end
        S_BIT_HG: begin
          if (cnt_q == hg_end_c) begin
            cnt_d   = '0;
            drive_d = 1'b1;
            if (idx_q == 6'd0) begin
              state_d = S_EOT;
            end else begin
              state_d = S_BIT_LW;
              idx_d   = idx_q - 6'd1;
            end
          end else cnt_d = cnt_t'(cnt_q + 1'b1);
        end
        S_EOT: begin
          if (cnt_q == EOT_END) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            drive_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else cnt_d = cnt_t'(cnt_q + 1'b1);
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          drive_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      line_s1_q <= 1'b1;
      line_s2_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      drive_q   <= drive_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      line_s1_q <= line_s1_d;
      line_s2_q <= line_s2_d;
    end
  end

  assign O_DRIVE_LOW = drive_q;
  assign O_BUSY      = busy_q;
  assign O_DONE      = done_q;

endmodule
